// File: rtl/seq_det_param_if.sv
// Bundles the serial-input qualifiers and the detector's status outputs.
// A master drives en/i/ovl/clr_cnt; the detector (slave) drives the status.
interface seq_det_param_if #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
);
  localparam int SW = $clog2(PAT_W + 1);

  logic             en;
  logic             i;
  logic             ovl;
  logic             clr_cnt;
  logic             q;
  logic [SW-1:0]    state_o;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output en, i, ovl, clr_cnt,
    input  q, state_o, match_cnt, cnt_sat
  );

  modport slave (
    input  en, i, ovl, clr_cnt,
    output q, state_o, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_det_param.sv
// Parameterised serial pattern detector: prefix-function (KMP) FSM with
// overlapping/non-overlapping mode and a saturating match counter.
module seq_det_param #(
  parameter int             PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter int             CNT_W   = 8
) (
  input  logic            clk,
  input  logic            rst,
  seq_det_param_if.slave  bus
);
  localparam int SW = $clog2(PAT_W + 1);
  localparam logic [SW-1:0]    S_IDLE  = '0;
  localparam logic [SW-1:0]    S_MATCH = SW'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Longest prefix of PATTERN that is a suffix of (first k pattern bits, b).
  // Prefix bit m is PATTERN[PAT_W-1-m] since the MSB is received first.
  function automatic int delta(input int k, input logic b);
    logic [PAT_W:0] s;
    logic           ok;
    int             res;
    s   = '0;
    res = 0;
    for (int m = 0; m < PAT_W; m++) begin
      if (m < k) s[m] = PATTERN[PAT_W-1-m];
    end
    s[k] = b;
    for (int j = 1; j <= PAT_W; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int m = 0; m < PAT_W; m++) begin
          if (m < j) begin
            if (s[k+1-j+m] != PATTERN[PAT_W-1-m]) ok = 1'b0;
          end
        end
        if (ok) res = j;
      end
    end
    return res;
  endfunction

  // Longest proper prefix of PATTERN that is also a suffix of it.
  function automatic int border();
    logic ok;
    int   res;
    res = 0;
    for (int j = 1; j < PAT_W; j++) begin
      ok = 1'b1;
      for (int m = 0; m < PAT_W; m++) begin
        if (m < j) begin
          if (PATTERN[PAT_W-1-m] != PATTERN[j-1-m]) ok = 1'b0;
        end
      end
      if (ok) res = j;
    end
    return res;
  endfunction

  // Row PAT_W (MATCH) resumes from the border: the overlapping-mode transition.
  logic [SW-1:0] nxt_tbl [0:PAT_W][0:1];
  for (genvar k = 0; k <= PAT_W; k++) begin : g_row
    localparam int START = (k == PAT_W) ? border() : k;
    assign nxt_tbl[k][0] = SW'(delta(START, 1'b0));
    assign nxt_tbl[k][1] = SW'(delta(START, 1'b1));
  end

  localparam logic [SW-1:0] IDLE_NXT0 = SW'(delta(0, 1'b0));
  localparam logic [SW-1:0] IDLE_NXT1 = SW'(delta(0, 1'b1));

  logic [SW-1:0]    state;
  logic [SW-1:0]    nxt;
  logic             hit;
  logic [CNT_W-1:0] cnt;
  logic             sat;

  always_comb begin
    nxt = state;
    hit = 1'b0;
    if (bus.en) begin
      if (state == S_MATCH && !bus.ovl) nxt = bus.i ? IDLE_NXT1 : IDLE_NXT0;
      else                              nxt = nxt_tbl[state][bus.i];
      hit = (nxt == S_MATCH);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      sat   <= 1'b0;
    end else begin
      state <= nxt;
      if (bus.clr_cnt) begin
        cnt <= '0;
        sat <= 1'b0;
      end else if (hit) begin
        if (cnt == CNT_MAX) sat <= 1'b1;
        else                cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.q         = (state == S_MATCH);
  assign bus.state_o   = state;
  assign bus.match_cnt = cnt;
  assign bus.cnt_sat   = sat;
endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboarded bench for seq_det_param: three instances (101 default,
// 101 with a 2-bit counter, 111) driven by directed bit streams.
module tb_seq_det_param;
  localparam int A = 0;
  localparam int B = 1;
  localparam int C = 2;

  typedef logic [11:0] exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_det_param_if #(.PAT_W(3), .CNT_W(8)) if_a ();
  seq_det_param_if #(.PAT_W(3), .CNT_W(2)) if_b ();
  seq_det_param_if #(.PAT_W(3), .CNT_W(8)) if_c ();

  seq_det_param #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  seq_det_param #(.PAT_W(3), .PATTERN(3'b101), .CNT_W(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  seq_det_param #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(8)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t exp_c[$];
  int   tests = 0;
  int   fails = 0;
  int   n_a = 0;
  int   n_b = 0;
  int   n_c = 0;

  task automatic check(input string name, input exp_t act, input exp_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got state=%0d q=%0b cnt=%0d sat=%0b, expected state=%0d q=%0b cnt=%0d sat=%0b",
               name, act[11:10], act[9], act[8:1], act[0], exp[11:10], exp[9], exp[8:1], exp[0]);
    end
  endtask

  // Monitor: compares each DUT's outputs just after the edge that consumed a stimulus.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_a.size() != 0) begin
        n_a++;
        check($sformatf("dut_a[%0d]", n_a),
              {if_a.state_o, if_a.q, 8'(if_a.match_cnt), if_a.cnt_sat}, exp_a.pop_front());
      end
      if (exp_b.size() != 0) begin
        n_b++;
        check($sformatf("dut_b[%0d]", n_b),
              {if_b.state_o, if_b.q, 8'(if_b.match_cnt), if_b.cnt_sat}, exp_b.pop_front());
      end
      if (exp_c.size() != 0) begin
        n_c++;
        check($sformatf("dut_c[%0d]", n_c),
              {if_c.state_o, if_c.q, 8'(if_c.match_cnt), if_c.cnt_sat}, exp_c.pop_front());
      end
    end
  end

  // Driver: applies one cycle of inputs to the selected DUT and queues the
  // hand-computed post-edge state, counter and saturation flag.
  task automatic step(input int sel, input logic r, input logic e, input logic b,
                      input logic o, input logic c, input int es, input int ec,
                      input logic esat);
    exp_t x;
    @(negedge clk);
    rst = r;
    if_a.en = 1'b0; if_a.clr_cnt = 1'b0; if_a.i = 1'b0; if_a.ovl = 1'b0;
    if_b.en = 1'b0; if_b.clr_cnt = 1'b0; if_b.i = 1'b0; if_b.ovl = 1'b0;
    if_c.en = 1'b0; if_c.clr_cnt = 1'b0; if_c.i = 1'b0; if_c.ovl = 1'b0;
    case (sel)
      A: begin if_a.en = e; if_a.i = b; if_a.ovl = o; if_a.clr_cnt = c; end
      B: begin if_b.en = e; if_b.i = b; if_b.ovl = o; if_b.clr_cnt = c; end
      default: begin if_c.en = e; if_c.i = b; if_c.ovl = o; if_c.clr_cnt = c; end
    endcase
    x = {es[1:0], 1'(es == 3), ec[7:0], esat};
    case (sel)
      A: exp_a.push_back(x);
      B: exp_b.push_back(x);
      default: exp_c.push_back(x);
    endcase
  endtask

  initial begin
    if_a.en = 1'b0; if_a.clr_cnt = 1'b0; if_a.i = 1'b0; if_a.ovl = 1'b0;
    if_b.en = 1'b0; if_b.clr_cnt = 1'b0; if_b.i = 1'b0; if_b.ovl = 1'b0;
    if_c.en = 1'b0; if_c.clr_cnt = 1'b0; if_c.i = 1'b0; if_c.ovl = 1'b0;

    // overlapping 1,0,1,0,1: matches after bits 3 and 5; reset overrides en/i
    step(A, 0, 1, 1, 1, 0, 0, 0, 0);
    step(A, 1, 1, 1, 1, 0, 1, 0, 0);
    step(A, 1, 1, 0, 1, 0, 2, 0, 0);
    step(A, 1, 1, 1, 1, 0, 3, 1, 0);
    step(A, 1, 1, 0, 1, 0, 2, 1, 0);
    step(A, 1, 1, 1, 1, 0, 3, 2, 0);

    // non-overlapping: only the first 101 counts, then 1,0,1 gives the second
    step(A, 0, 0, 0, 0, 1, 0, 0, 0);
    step(A, 1, 1, 1, 0, 0, 1, 0, 0);
    step(A, 1, 1, 0, 0, 0, 2, 0, 0);
    step(A, 1, 1, 1, 0, 0, 3, 1, 0);
    step(A, 1, 1, 0, 0, 0, 0, 1, 0);
    step(A, 1, 1, 1, 0, 0, 1, 1, 0);
    step(A, 1, 1, 1, 0, 0, 1, 1, 0);
    step(A, 1, 1, 0, 0, 0, 2, 1, 0);
    step(A, 1, 1, 1, 0, 0, 3, 2, 0);

    // 1,1,0,1: second 1 falls back to S1, not S0
    step(A, 0, 0, 0, 1, 0, 0, 0, 0);
    step(A, 1, 1, 1, 1, 0, 1, 0, 0);
    step(A, 1, 1, 1, 1, 0, 1, 0, 0);
    step(A, 1, 1, 0, 1, 0, 2, 0, 0);
    step(A, 1, 1, 1, 1, 0, 3, 1, 0);

    // en=0 holds state while i/ovl toggle; q held after the match
    step(A, 0, 0, 0, 1, 0, 0, 0, 0);
    step(A, 1, 1, 1, 1, 0, 1, 0, 0);
    step(A, 1, 1, 0, 1, 0, 2, 0, 0);
    for (int k = 0; k < 5; k++) step(A, 1, 0, 1'(k), 1'(k + 1), 0, 2, 0, 0);
    step(A, 1, 1, 1, 1, 0, 3, 1, 0);
    for (int k = 0; k < 3; k++) step(A, 1, 0, 1'(k), 1'(k), 0, 3, 1, 0);
    step(A, 1, 0, 0, 1, 1, 3, 0, 0);

    // reset mid-sequence discards the prefix and the count
    step(A, 0, 0, 0, 1, 0, 0, 0, 0);
    step(A, 1, 1, 1, 1, 0, 1, 0, 0);
    step(A, 1, 1, 0, 1, 0, 2, 0, 0);
    step(A, 1, 1, 1, 1, 0, 3, 1, 0);
    step(A, 1, 1, 1, 1, 0, 1, 1, 0);
    step(A, 0, 1, 0, 1, 1, 0, 0, 0);
    step(A, 1, 1, 1, 1, 0, 1, 0, 0);
    step(A, 1, 1, 0, 1, 0, 2, 0, 0);
    step(A, 1, 1, 0, 1, 0, 0, 0, 0);

    // 2-bit counter saturates at 3; clear wins over a coincident match
    step(B, 0, 0, 0, 1, 0, 0, 0, 0);
    step(B, 1, 1, 1, 1, 0, 1, 0, 0);
    step(B, 1, 1, 0, 1, 0, 2, 0, 0);
    step(B, 1, 1, 1, 1, 0, 3, 1, 0);
    step(B, 1, 1, 0, 1, 0, 2, 1, 0);
    step(B, 1, 1, 1, 1, 0, 3, 2, 0);
    step(B, 1, 1, 0, 1, 0, 2, 2, 0);
    step(B, 1, 1, 1, 1, 0, 3, 3, 0);
    step(B, 1, 1, 0, 1, 0, 2, 3, 0);
    step(B, 1, 1, 1, 1, 0, 3, 3, 1);
    step(B, 1, 1, 0, 1, 0, 2, 3, 1);
    step(B, 1, 1, 1, 1, 1, 3, 0, 0);
    step(B, 1, 1, 0, 1, 0, 2, 0, 0);
    step(B, 1, 1, 1, 1, 0, 3, 1, 0);

    // all-ones pattern: MATCH-to-MATCH in overlap mode, S1 restart otherwise
    step(C, 0, 0, 0, 1, 0, 0, 0, 0);
    step(C, 1, 1, 1, 1, 0, 1, 0, 0);
    step(C, 1, 1, 1, 1, 0, 2, 0, 0);
    step(C, 1, 1, 1, 1, 0, 3, 1, 0);
    step(C, 1, 1, 1, 1, 0, 3, 2, 0);
    step(C, 1, 1, 0, 1, 0, 0, 2, 0);
    step(C, 1, 1, 1, 0, 0, 1, 2, 0);
    step(C, 1, 1, 1, 0, 0, 2, 2, 0);
    step(C, 1, 1, 1, 0, 0, 3, 3, 0);
    step(C, 1, 1, 1, 0, 0, 1, 3, 0);
    step(C, 1, 1, 0, 0, 0, 0, 3, 0);

    @(negedge clk);
    if_c.en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    if (exp_a.size() + exp_b.size() + exp_c.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d unchecked expectations, expected 0",
               exp_a.size() + exp_b.size() + exp_c.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_det_param.md
SEQ_DET_PARAM -- requirements
Module: seq_det_param

Interface
REQ-001 Parameter PAT_W, default 3, pattern length in bits; legal range 2..16.
REQ-002 Parameter PATTERN, default 3'b101, PAT_W-bit target pattern; PATTERN[PAT_W-1] is the first bit received.
REQ-003 Parameter CNT_W, default 8, match counter width; legal range 1..32.
REQ-004 Port clk  input  1  single clock; all state changes on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-low: sampled only at the rising edge of clk, and rst low at that edge resets the block.
REQ-006 Port en  input  1  bit-valid qualifier; i is accepted only at an edge where en=1.
REQ-007 Port i  input  1  serial data bit.
REQ-008 Port ovl  input  1  mode: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 Port clr_cnt  input  1  synchronous clear of match_cnt and cnt_sat.
REQ-010 Port q  output  1  Moore match flag, decoded from state only.
REQ-011 Port state_o  output  $clog2(PAT_W+1)  current state (number of pattern bits matched), for debug.
REQ-012 Port match_cnt  output  CNT_W  count of matches since reset/clear.
REQ-013 Port cnt_sat  output  1  sticky flag: match_cnt has saturated.

Function
REQ-014 The FSM SHALL have PAT_W+1 states S0..S(PAT_W); Sk means the last k accepted bits equal the first k bits of PATTERN; S(PAT_W) is MATCH.
REQ-015 In S0..S(PAT_W-1), on an accepted bit the next state SHALL be the longest k such that the first k bits of PATTERN equal the last k bits of (current matched prefix followed by i), i.e. full prefix-function fallback, not blind return to S0.
REQ-016 From MATCH with ovl=1, the next state SHALL be computed as in REQ-015, starting from the longest proper prefix of PATTERN that is also its suffix.
REQ-017 From MATCH with ovl=0, the next state SHALL be computed as in REQ-015 starting from S0 (no bits of the completed match reused).
REQ-018 ovl SHALL be sampled at the same edge as the accepted bit; a change of ovl affects only transitions out of MATCH.
REQ-019 With en=0 the state SHALL hold; i and ovl are ignored.
REQ-020 q SHALL be 1 exactly while state is MATCH: rises in the cycle after the edge accepting the last pattern bit, held while en=0, falls after the next accepted bit unless that bit completes a new match (overlap).
REQ-021 match_cnt SHALL increment by 1 at every edge where state enters MATCH, including MATCH-to-MATCH transitions.
REQ-022 match_cnt SHALL saturate at 2^CNT_W-1; an increment attempt at saturation sets cnt_sat=1 and leaves match_cnt unchanged.
REQ-023 clr_cnt=1 SHALL set match_cnt=0 and cnt_sat=0 at that edge, with priority over a simultaneous increment; FSM unaffected.
REQ-024 Behaviour for PATTERN of all-identical bits (e.g. 3'b111) SHALL follow REQ-015/016 without special casing.

Reset
REQ-025 rst=0 at a rising edge SHALL force state S0, q=0, match_cnt=0, cnt_sat=0, overriding en, clr_cnt and i.
REQ-026 Reset mid-sequence SHALL discard any partial prefix; detection restarts with the first bit accepted after rst returns to 1.
REQ-027 Outputs SHALL be undefined only before the first reset edge; no asynchronous path from rst exists.

Verification
REQ-028 Defaults, ovl=1, en=1, bits 1,0,1,0,1 -> q high in cycles after bits 3 and 5, match_cnt=2.
REQ-029 Defaults, ovl=0, same stream 1,0,1,0,1 -> q high only after bit 3, match_cnt=1; then 1,0,1 -> match_cnt=2.
REQ-030 Defaults, bits 1,1,0,1 -> fallback S1 on second 1, match after bit 4, match_cnt=1 (no false reset to S0).
REQ-031 Defaults, bits 1,0 then en=0 for 5 cycles with i toggling, then en=1 bit 1 -> state held at S2, match after resume, q held high while en=0 afterwards.
REQ-032 CNT_W=2, ovl=1, stream 1,0,1,0,1,0,1,0,1 -> match_cnt 1,2,3,3; cnt_sat=1 at 4th match; clr_cnt coincident with 5th match -> match_cnt=0, cnt_sat=0.
REQ-033 rst=0 asserted at the edge accepting bit 2 of 1,0,1 -> state S0, match_cnt=0; following bit 1 alone produces no match.
